// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command-issue slice: opcodes, FSM encoding,
// command record and opcode classification helpers.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_SEQ  = 4'hA;
   localparam logic [3:0] OP_IDLE = 4'hF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CAPT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int CMD_W = 12;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] a;
      logic [3:0] b;
   } cmd_t;

   // 0xB-0xE are undefined; 0xF is the ALU's idle code and never accepted from users
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_SEQ);
   endfunction

   function automatic logic has_flags(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x WIDTH) with occupancy count.
// Push is ignored when full and pop when empty, regardless of the other side.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command issue stage for the registered 4-bit ALU: queues commands, issues one at a time,
// returns result/flags on a valid/ready port. ALU_ISSUE_STATS_EN adds a response counter.
module alu_cmd_issue
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_opcode,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   output logic [7:0] alu_operands,
   output logic [3:0] alu_opcode,
   input  logic [7:0] alu_result,
   input  logic [1:0] alu_flags,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic [1:0] rsp_flags,
   output logic       rsp_err
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [7:0] stat_count
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [CMD_W-1:0] fifo_rd;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             load;
   logic             head_legal;
   cmd_t             head;

   assign cmd_ready  = (fifo_count != CW'(DEPTH));
   assign push       = cmd_valid && !fifo_full;
   assign head       = cmd_t'(fifo_rd);
   assign head_legal = is_legal_op(head.opcode);
   assign rsp_valid  = (state == ST_RESP);

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data ({cmd_opcode, cmd_a, cmd_b}),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Illegal heads walk through IDLE/CAPT like any other command but the ALU only ever sees OP_IDLE
   always_comb begin
      state_next   = state;
      alu_opcode   = OP_IDLE;
      alu_operands = 8'h00;
      pop          = 1'b0;
      load         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (head_legal) begin
                  alu_opcode   = head.opcode;
                  alu_operands = {head.a, head.b};
               end
               state_next = ST_CAPT;
            end
         end
         ST_CAPT: begin
            if (head_legal) begin
               alu_opcode   = head.opcode;
               alu_operands = {head.a, head.b};
            end
            load       = 1'b1;
            pop        = 1'b1;
            state_next = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // The ALU holds stale flags for non-ADD/SUB ops, so they are masked on capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result <= 8'h00;
         rsp_flags  <= 2'b00;
         rsp_err    <= 1'b0;
      end else if (load) begin
         if (head_legal) begin
            rsp_result <= alu_result;
            rsp_flags  <= has_flags(head.opcode) ? alu_flags : 2'b00;
            rsp_err    <= 1'b0;
         end else begin
            rsp_result <= 8'h00;
            rsp_flags  <= 2'b00;
            rsp_err    <= 1'b1;
         end
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_count <= 8'h00;
      end else if (rsp_valid && rsp_ready && (stat_count != 8'hFF)) begin
         stat_count <= stat_count + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue with a behavioural registered 4-bit ALU attached.
// Table-driven single-command vectors plus hand-written full-FIFO and mid-operation reset sequences.
module tb_alu_cmd_issue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_opcode;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [7:0] alu_operands;
   logic [3:0] alu_opcode;
   logic [7:0] alu_result;
   logic [1:0] alu_flags;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic [1:0] rsp_flags;
   logic       rsp_err;
`ifdef ALU_ISSUE_STATS_EN
   logic [7:0] stat_count;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int n_hs  = 0;

   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exp_result;
      logic [1:0] exp_flags;
      logic       exp_err;
   } vec_t;

   vec_t vecs[12];
   vec_t qvec[5];

   always #5 clk = ~clk;

   alu_cmd_issue #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .alu_operands (alu_operands),
      .alu_opcode   (alu_opcode),
      .alu_result   (alu_result),
      .alu_flags    (alu_flags),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_flags    (rsp_flags),
      .rsp_err      (rsp_err)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .stat_count   (stat_count)
`endif
   );

   // Behavioural registered ALU: flags only updated by ADD/SUB, stale otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      logic [3:0] a, b;
      logic [4:0] s;
      if (!rst_n) begin
         alu_result <= 8'h00;
         alu_flags  <= 2'b00;
      end else begin
         a = alu_operands[7:4];
         b = alu_operands[3:0];
         case (alu_opcode)
            4'h0: begin
               s = {1'b0, a} + {1'b0, b};
               alu_result <= {4'h0, s[3:0]};
               alu_flags  <= {(a[3] == b[3]) && (s[3] != a[3]), s[4]};
            end
            4'h1: begin
               s = {1'b0, a} - {1'b0, b};
               alu_result <= {4'h0, s[3:0]};
               alu_flags  <= {(a[3] != b[3]) && (s[3] != a[3]), a >= b};
            end
            4'h2: alu_result <= {4'h0, a} * {4'h0, b};
            4'h3: alu_result <= (b == 4'h0) ? 8'h00 : {a % b, a / b};
            4'h4: alu_result <= {4'h0, a & b};
            4'h5: alu_result <= {4'h0, a | b};
            4'h6: alu_result <= {4'h0, a ^ b};
            4'h7: alu_result <= {4'h0, ~a};
            4'h8: alu_result <= {4'h0, a << b[1:0]};
            4'h9: alu_result <= {4'h0, a >> b[1:0]};
            4'hA: alu_result <= {7'h00, a == b};
            default: alu_result <= 8'h00;
         endcase
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       n_hs <= 0;
      else if (rsp_valid && rsp_ready && n_hs < 255) n_hs <= n_hs + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(input string name);
      int n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
   endtask

   task automatic check_rsp(input string name, input vec_t v);
      check({name, " result"}, 32'(rsp_result), 32'(v.exp_result));
      check({name, " flags"},  32'(rsp_flags),  32'(v.exp_flags));
      check({name, " err"},    32'(rsp_err),    32'(v.exp_err));
   endtask

   // Drives one command at a negedge; it is accepted at the following posedge
   task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
   endtask

   task automatic check_output(input string name, input vec_t v);
      logic legal;
      legal = (v.op <= 4'hA);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check({name, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({name, " idle alu_opcode"}, 32'(alu_opcode), legal ? 32'(v.op) : 32'hF);
      check({name, " idle alu_operands"}, 32'(alu_operands), legal ? 32'({v.a, v.b}) : 32'h0);
      @(negedge clk);
      check({name, " capt rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({name, " capt alu_opcode"}, 32'(alu_opcode), legal ? 32'(v.op) : 32'hF);
      @(negedge clk);
      check({name, " latency rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, " resp alu_opcode"}, 32'(alu_opcode), 32'hF);
      check_rsp(name, v);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({name, " after hs rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{4'h0, 4'h7, 4'h9, 8'h00, 2'b01, 1'b0};
      vecs[1]  = '{4'h2, 4'hF, 4'hF, 8'hE1, 2'b00, 1'b0};
      vecs[2]  = '{4'hC, 4'h3, 4'h2, 8'h00, 2'b00, 1'b1};
      vecs[3]  = '{4'h1, 4'h3, 4'h5, 8'h0E, 2'b00, 1'b0};
      vecs[4]  = '{4'h3, 4'h9, 4'h0, 8'h00, 2'b00, 1'b0};
      vecs[5]  = '{4'h3, 4'h9, 4'h2, 8'h14, 2'b00, 1'b0};
      vecs[6]  = '{4'h0, 4'h7, 4'h1, 8'h08, 2'b10, 1'b0};
      vecs[7]  = '{4'h1, 4'h8, 4'h1, 8'h07, 2'b11, 1'b0};
      vecs[8]  = '{4'h4, 4'hC, 4'hA, 8'h08, 2'b00, 1'b0};
      vecs[9]  = '{4'hF, 4'h1, 4'h1, 8'h00, 2'b00, 1'b1};
      vecs[10] = '{4'h6, 4'h5, 4'h3, 8'h06, 2'b00, 1'b0};
      vecs[11] = '{4'hB, 4'h4, 4'h4, 8'h00, 2'b00, 1'b1};

      qvec[0] = '{4'h0, 4'h1, 4'h2, 8'h03, 2'b00, 1'b0};
      qvec[1] = '{4'h1, 4'h9, 4'h4, 8'h05, 2'b11, 1'b0};
      qvec[2] = '{4'h2, 4'h3, 4'h4, 8'h0C, 2'b00, 1'b0};
      qvec[3] = '{4'h3, 4'h7, 4'h2, 8'h13, 2'b00, 1'b0};
      qvec[4] = '{4'h6, 4'h5, 4'h3, 8'h06, 2'b00, 1'b0};

      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_opcode = 4'h0;
      cmd_a      = 4'h0;
      cmd_b      = 4'h0;
      rsp_ready  = 1'b0;
      #1;
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset alu_opcode", 32'(alu_opcode), 32'hF);
      check("reset alu_operands", 32'(alu_operands), 32'h0);
      check("reset rsp_result", 32'(rsp_result), 32'h0);
      check("reset rsp_flags", 32'(rsp_flags), 32'h0);
      check("reset rsp_err", 32'(rsp_err), 32'h0);
`ifdef ALU_ISSUE_STATS_EN
      check("reset stat_count", 32'(stat_count), 32'h0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         check($sformatf("vec%0d cmd_ready", i), 32'(cmd_ready), 32'd1);
         apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         check_output($sformatf("vec%0d", i), vecs[i]);
      end

      // Fill with the response port stalled: one in RESP plus four queued, sixth refused
      for (int i = 0; i < 6; i++) begin
         check($sformatf("fill%0d cmd_ready", i), 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
         if (i < 5) apply_stimulus(qvec[i].op, qvec[i].a, qvec[i].b);
         else       apply_stimulus(4'h5, 4'h1, 4'h2);
         @(negedge clk);
      end
      check("full cmd_ready held", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_rsp($sformatf("drain%0d", i));
         check_rsp($sformatf("drain%0d", i), qvec[i]);
         @(negedge clk);
         @(negedge clk);
         check_rsp($sformatf("drain%0d stalled", i), qvec[i]);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
      for (int i = 0; i < 4; i++) @(negedge clk);
      check("drained rsp_valid", 32'(rsp_valid), 32'd0);
      check("drained cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef ALU_ISSUE_STATS_EN
      check("stat_count before reset", 32'(stat_count), 32'(n_hs));
`endif

      // Reach CAPT on the second command with three entries still queued, then reset
      apply_stimulus(4'h0, 4'h1, 4'h1); @(negedge clk);
      apply_stimulus(4'h1, 4'h6, 4'h2); @(negedge clk);
      apply_stimulus(4'h2, 4'h2, 4'h2); @(negedge clk);
      apply_stimulus(4'h5, 4'h1, 4'h4); @(negedge clk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      @(negedge clk);
      check("pre-reset capt alu_opcode", 32'(alu_opcode), 32'h1);
      check("pre-reset capt alu_operands", 32'(alu_operands), 32'h62);
      rst_n = 1'b0;
      #1;
      check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid reset alu_opcode", 32'(alu_opcode), 32'hF);
`ifdef ALU_ISSUE_STATS_EN
      check("mid reset stat_count", 32'(stat_count), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("post reset quiet%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
      end
      rsp_ready = 1'b0;
      apply_stimulus(4'h0, 4'h2, 4'h3);
      check_output("post reset add", '{4'h0, 4'h2, 4'h3, 8'h05, 2'b00, 1'b0});
`ifdef ALU_ISSUE_STATS_EN
      check("final stat_count", 32'(stat_count), 32'(n_hs));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
